vmove_issue: RTL and testbench
==============================

Name: vmove_issue

Overview:
- Issue sequencer directly upstream of the vector move pipe in the vALU.
- Accepts one move command: destination base address, beat count, and source mode (vector stream, or scalar splat).
- Emits one request beat per cycle on the move pipe's input triple (addr/vec/valid), with an incrementing beat address.
- The move pipe has no backpressure, so this block is the only point of flow control on the move path.

Parameters:
- REQ_DATA_WIDTH, 64, beat data width; equals the move pipe's data input width.
- REQ_ADDR_WIDTH, 32, beat address width.
- SEW_WIDTH, 2, element-width selector width.
- LEN_WIDTH, 8, beat-count width.
- XLEN, 64, scalar operand width; must be >= 64 when splat is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid is high in the same cycle
- cmd_addr  in  REQ_ADDR_WIDTH  destination base beat address
- cmd_len  in  LEN_WIDTH  number of beats to issue
- cmd_scalar  in  1  1 = splat cmd_xdata; 0 = stream src_data
- cmd_sew  in  SEW_WIDTH  element width: 0=8b, 1=16b, 2=32b, 3=64b
- cmd_xdata  in  XLEN  scalar operand
- src_valid  in  1  source beat available
- src_ready  out  1  source beat consumed when src_valid is high in the same cycle
- src_data  in  REQ_DATA_WIDTH  source beat
- out_addr  out  REQ_ADDR_WIDTH  beat address to move pipe
- out_vec  out  REQ_DATA_WIDTH  beat data to move pipe
- out_valid  out  1  beat valid to move pipe
- busy  out  1  high while state is RUN

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state goes to IDLE.
  - out_addr, out_vec, out_valid all 0.
  - Internal beat counter, base address, mode, SEW and splat value all 0.
  - Reset mid-RUN aborts the command; no further beats are issued; no pending state survives.
- FSM states: IDLE, RUN.
- cmd_ready = (state==IDLE) and not rst. Combinational from state only.
- Command acceptance (IDLE, cmd_valid & cmd_ready):
  - Capture cmd_addr, cmd_len, cmd_scalar, cmd_sew and the splat value.
  - cmd_len==0: command is consumed, no beat is issued, state stays IDLE.
  - cmd_len!=0: state goes to RUN, beat counter := 0.
- src_ready = (state==RUN) & ~mode_scalar. Combinational; src_ready is never high in IDLE.
- Beat issue in RUN:
  - Vector mode: issue on src_valid & src_ready.
  - Scalar mode: issue every cycle.
- Issue timing and data:
  - Issue in cycle N gives out_valid=1 in cycle N+1 (one register stage).
  - out_addr = base + counter, modulo 2^REQ_ADDR_WIDTH; wraps silently.
  - out_vec = src_data (vector mode) or splat value (scalar mode).
  - Then counter := counter + 1.
- No issue in a cycle: out_valid=0 next cycle, and out_vec and out_addr are forced to 0 next cycle (zero-gated like the pipe).
- Last beat: when the issuing beat has counter == len-1, state goes to IDLE at the same edge.
  - cmd_ready is high the following cycle.
  - Back-to-back commands therefore have exactly one idle cycle between the last beat of one and the first beat of the next.
- Vector-mode source gaps: src_valid low in RUN produces a bubble (out_valid=0); counter holds.
- busy = (state==RUN).
- Max beats per command: 2^LEN_WIDTH - 1.

Optional Feature:
- Macro: VMOVE_SPLAT_EN.
- Defined:
  - Splat value is the low SEW bits of cmd_xdata, replicated across REQ_DATA_WIDTH.
  - Example: sew=0 with xdata 0xAB gives 0xABAB_ABAB_ABAB_ABAB.
  - Splat value is captured at command acceptance.
- Undefined:
  - cmd_scalar is ignored and treated as 0; every command is vector mode.
  - cmd_sew and cmd_xdata are unused; no splat logic is synthesised.

Test Plan:
- Reset, then vector cmd addr=0x100, len=3; src beats 0x11, 0x22, 0x33 held valid -> out_valid on 3 consecutive cycles with (0x100,0x11), (0x101,0x22), (0x102,0x33); busy drops after the 3rd issue; cmd_ready high the next cycle.
- Vector cmd len=4 with src_valid pattern 1,0,0,1,1,1 -> exactly 4 beats with 2 bubble cycles; out_vec=0 and out_addr=0 in bubbles; addresses contiguous.
- cmd_len=0 at addr 0x40 -> cmd_ready stays high, busy never asserts, no out_valid.
- Splat (VMOVE_SPLAT_EN) sew=1, xdata=0x1234_5678, len=2, addr=0xFFFF_FFFF -> out_vec=0x5678_5678_5678_5678 twice; addresses 0xFFFF_FFFF then 0x0000_0000; src_ready stays 0.
- rst pulsed for 1 cycle during beat 2 of a len=8 command -> out_valid=0, out_addr=0, out_vec=0 from the next cycle; state IDLE; cmd_ready=1 after rst deasserts; no further beats.
- Two back-to-back commands, len=2 each, cmd_valid held high -> beats, one gap cycle, beats; the second command's addresses start at its own base.

Source files
------------

// File: rtl/vmove_issue.sv
// Issue sequencer feeding the vector move pipe: one command in, one addr/vec beat per cycle out.
// Optional scalar splat source is compiled in with VMOVE_SPLAT_EN.
module vmove_issue #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int SEW_WIDTH      = 2,
    parameter int LEN_WIDTH      = 8,
    parameter int XLEN           = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [REQ_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      cmd_scalar,
    input  logic [SEW_WIDTH-1:0]      cmd_sew,
    input  logic [XLEN-1:0]           cmd_xdata,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [REQ_DATA_WIDTH-1:0] src_data,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic [REQ_DATA_WIDTH-1:0] out_vec,
    output logic                      out_valid,
    output logic                      busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [REQ_ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [REQ_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [REQ_DATA_WIDTH-1:0] out_vec_q, out_vec_d;
    logic                      out_valid_q, out_valid_d;
    logic                      mode;
    logic [REQ_DATA_WIDTH-1:0] beat_data;
    logic                      accept;
    logic                      issue;

`ifdef VMOVE_SPLAT_EN
    logic                      mode_q, mode_d;
    logic [REQ_DATA_WIDTH-1:0] splat_q, splat_d, splat_val;

    // Element replicated across the beat; captured once at command acceptance.
    always_comb begin
        splat_val = '0;
        case (cmd_sew)
            2'd0:    splat_val = {(REQ_DATA_WIDTH/8){cmd_xdata[7:0]}};
            2'd1:    splat_val = {(REQ_DATA_WIDTH/16){cmd_xdata[15:0]}};
            2'd2:    splat_val = {(REQ_DATA_WIDTH/32){cmd_xdata[31:0]}};
            default: splat_val = {(REQ_DATA_WIDTH/64){cmd_xdata[63:0]}};
        endcase
    end

    assign mode      = mode_q;
    assign beat_data = mode_q ? splat_q : src_data;
`else
    logic unused_cmd;
    assign unused_cmd = ^{cmd_scalar, cmd_sew, cmd_xdata};
    assign mode       = 1'b0;
    assign beat_data  = src_data;
`endif

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign src_ready = (state_q == RUN) && !mode;
    assign busy      = (state_q == RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign issue     = (state_q == RUN) && (mode || src_valid);

    assign out_addr  = out_addr_q;
    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_addr_d  = '0;
        out_vec_d   = '0;
`ifdef VMOVE_SPLAT_EN
        mode_d      = mode_q;
        splat_d     = splat_q;
`endif
        if (accept) begin
            base_d = cmd_addr;
            len_d  = cmd_len;
            cnt_d  = '0;
`ifdef VMOVE_SPLAT_EN
            mode_d  = cmd_scalar;
            splat_d = splat_val;
`endif
            if (cmd_len != '0) begin
                state_d = RUN;
            end
        end
        if (issue) begin
            out_valid_d = 1'b1;
            out_addr_d  = base_q + REQ_ADDR_WIDTH'(cnt_q);
            out_vec_d   = beat_data;
            cnt_d       = cnt_q + LEN_WIDTH'(1);
            if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_vec_q   <= '0;
`ifdef VMOVE_SPLAT_EN
            mode_q      <= 1'b0;
            splat_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_vec_q   <= out_vec_d;
`ifdef VMOVE_SPLAT_EN
            mode_q      <= mode_d;
            splat_q     <= splat_d;
`endif
        end
    end

endmodule

// File: tb/tb_vmove_issue.sv
// Directed bench for vmove_issue; the splat case is compiled only with VMOVE_SPLAT_EN.
module tb_vmove_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_scalar;
    logic [1:0]  cmd_sew;
    logic [63:0] cmd_xdata;
    logic        src_valid;
    logic        src_ready;
    logic [63:0] src_data;
    logic [31:0] out_addr;
    logic [63:0] out_vec;
    logic        out_valid;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    vmove_issue #(
        .REQ_DATA_WIDTH(64),
        .REQ_ADDR_WIDTH(32),
        .SEW_WIDTH(2),
        .LEN_WIDTH(8),
        .XLEN(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_scalar(cmd_scalar),
        .cmd_sew(cmd_sew), .cmd_xdata(cmd_xdata),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .out_addr(out_addr), .out_vec(out_vec), .out_valid(out_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic v, input logic [31:0] a, input logic [63:0] d);
        check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        check({tag, ".addr"}, {32'd0, out_addr}, {32'd0, a});
        check({tag, ".vec"}, out_vec, d);
    endtask

    logic        pat_v [6];
    logic [63:0] pat_d [6];
    logic        exp_v [6];
    logic [31:0] exp_a [6];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_scalar = 1'b0;
        cmd_sew = '0; cmd_xdata = '0; src_valid = 1'b0; src_data = '0;
        step();
        step();
        beat("reset", 1'b0, 32'h0, 64'h0);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.cmd_ready_in_rst", {63'd0, cmd_ready}, 64'd0);
        check("reset.src_ready", {63'd0, src_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("idle.cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Vector, len 3, source always valid
        cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3;
        src_valid = 1'b1; src_data = 64'h11;
        step();
        cmd_valid = 1'b0;
        check("v3.busy_run", {63'd0, busy}, 64'd1);
        check("v3.cmd_ready_run", {63'd0, cmd_ready}, 64'd0);
        check("v3.src_ready_run", {63'd0, src_ready}, 64'd1);
        check("v3.no_beat_yet", {63'd0, out_valid}, 64'd0);
        step(); beat("v3.b0", 1'b1, 32'h100, 64'h11); src_data = 64'h22;
        step(); beat("v3.b1", 1'b1, 32'h101, 64'h22); src_data = 64'h33;
        step(); beat("v3.b2", 1'b1, 32'h102, 64'h33);
        check("v3.busy_done", {63'd0, busy}, 64'd0);
        check("v3.cmd_ready_done", {63'd0, cmd_ready}, 64'd1);
        src_valid = 1'b0;
        step(); beat("v3.after", 1'b0, 32'h0, 64'h0);

        // Vector, len 4, source pattern 1,0,0,1,1,1
        pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        pat_d = '{64'hA0, 64'hDEAD, 64'hBEEF, 64'hA1, 64'hA2, 64'hA3};
        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_a = '{32'h200, 32'h0, 32'h0, 32'h201, 32'h202, 32'h203};
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd4;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src_valid = pat_v[i];
            src_data  = pat_d[i];
            step();
            beat($sformatf("v4.c%0d", i), exp_v[i], exp_a[i], exp_v[i] ? pat_d[i] : 64'h0);
        end
        check("v4.busy_done", {63'd0, busy}, 64'd0);
        src_valid = 1'b0;

        // Zero-length command
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_len = 8'd0; src_valid = 1'b1; src_data = 64'h99;
        step();
        cmd_valid = 1'b0;
        check("z.busy", {63'd0, busy}, 64'd0);
        check("z.cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("z.src_ready", {63'd0, src_ready}, 64'd0);
        step();
        beat("z.nobeat", 1'b0, 32'h0, 64'h0);
        src_valid = 1'b0;

`ifdef VMOVE_SPLAT_EN
        // Scalar splat with address wrap
        cmd_valid = 1'b1; cmd_addr = 32'hFFFF_FFFF; cmd_len = 8'd2; cmd_scalar = 1'b1;
        cmd_sew = 2'd1; cmd_xdata = 64'h1234_5678;
        step();
        cmd_valid = 1'b0; cmd_scalar = 1'b0; cmd_xdata = '0;
        check("s.src_ready", {63'd0, src_ready}, 64'd0);
        step(); beat("s.b0", 1'b1, 32'hFFFF_FFFF, 64'h5678_5678_5678_5678);
        check("s.src_ready_b0", {63'd0, src_ready}, 64'd0);
        step(); beat("s.b1", 1'b1, 32'h0000_0000, 64'h5678_5678_5678_5678);
        check("s.busy_done", {63'd0, busy}, 64'd0);
`endif

        // Reset during beat 2 of a len 8 command
        cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_len = 8'd8; src_valid = 1'b1; src_data = 64'h55;
        step();
        cmd_valid = 1'b0;
        step(); beat("r.b0", 1'b1, 32'h300, 64'h55);
        step(); beat("r.b1", 1'b1, 32'h301, 64'h55);
        rst = 1'b1;
        step();
        beat("r.in_rst", 1'b0, 32'h0, 64'h0);
        check("r.busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        #1;
        check("r.cmd_ready", {63'd0, cmd_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            beat($sformatf("r.quiet%0d", i), 1'b0, 32'h0, 64'h0);
        end
        src_valid = 1'b0;

        // Back-to-back commands with cmd_valid held
        cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_len = 8'd2; src_valid = 1'b1; src_data = 64'h77;
        step();
        cmd_addr = 32'h600;
        step(); beat("bb.a0", 1'b1, 32'h500, 64'h77);
        step(); beat("bb.a1", 1'b1, 32'h501, 64'h77);
        check("bb.cmd_ready_gap", {63'd0, cmd_ready}, 64'd1);
        step(); beat("bb.gap", 1'b0, 32'h0, 64'h0);
        cmd_valid = 1'b0;
        check("bb.busy2", {63'd0, busy}, 64'd1);
        step(); beat("bb.b0", 1'b1, 32'h600, 64'h77);
        step(); beat("bb.b1", 1'b1, 32'h601, 64'h77);
        check("bb.busy_done", {63'd0, busy}, 64'd0);
        src_valid = 1'b0;
        step(); beat("bb.end", 1'b0, 32'h0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
